// File: rtl/imem_stream_loader.sv
// -----------------------------------------------------------------------------
// imem_stream_loader
//
// Receives a program as a valid/ready byte stream, assembles little-endian
// 32-bit words, writes them into instruction memory and checks an XOR checksum
// over the data bytes. When the checksum matches, the core is released from
// reset.
//
// Stream format: N[7:0], N[15:8], 4*N data bytes (LSB of each word first),
// then one checksum byte equal to the XOR of all data bytes.
//
// Parameters
//   DEPTH_WORDS  instruction memory capacity in words (1..65535)
//   BASE_ADDR    byte address of word 0 (word aligned)
//
// Ports
//   clk          clock
//   rst          asynchronous active-low reset
//   start        one-cycle pulse, starts a (re)load from IDLE/DONE/ERR
//   s_valid      byte stream valid
//   s_ready      byte stream ready
//   s_data       byte stream data
//   imem_we      instruction memory write enable, one cycle per word
//   imem_addr    byte address of the word being written
//   imem_wdata   assembled word
//   core_rst     active-high reset to the core, low only after a good load
//   busy         high from LEN_LO through CSUM
//   done         load completed and checksum matched
//   err          length out of range or checksum mismatch
//   words_loaded words written in the current load
// -----------------------------------------------------------------------------
module imem_stream_loader #(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [7:0]  s_data,
  output logic        imem_we,
  output logic [31:0] imem_addr,
  output logic [31:0] imem_wdata,
  output logic        core_rst,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [15:0] words_loaded
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LEN_LO = 3'd1,
    ST_LEN_HI = 3'd2,
    ST_DATA   = 3'd3,
    ST_WRITE  = 3'd4,
    ST_CSUM   = 3'd5,
    ST_DONE   = 3'd6,
    ST_ERR    = 3'd7
  } state_t;

  // One extra bit so the length compare covers DEPTH_WORDS = 65535.
  localparam logic [16:0] DEPTH_LIMIT = DEPTH_WORDS[16:0];

  // Byte-consuming states drive s_ready.
  function automatic logic ready_in(input state_t st);
    case (st)
      ST_LEN_LO, ST_LEN_HI, ST_DATA, ST_CSUM: ready_in = 1'b1;
      default:                                ready_in = 1'b0;
    endcase
  endfunction

  // Every state between the start of a load and its verdict is busy.
  function automatic logic busy_in(input state_t st);
    case (st)
      ST_LEN_LO, ST_LEN_HI, ST_DATA, ST_WRITE, ST_CSUM: busy_in = 1'b1;
      default:                                          busy_in = 1'b0;
    endcase
  endfunction

  state_t      state_q;
  state_t      state_d;
  logic        s_ready_q;
  logic        imem_we_q;
  logic [31:0] imem_addr_q;
  logic [31:0] imem_wdata_q;
  logic        core_rst_q;
  logic        busy_q;
  logic        done_q;
  logic        err_q;
  logic [15:0] words_loaded_q;
  logic [7:0]  len_lo_q;
  logic [15:0] len_q;
  logic [23:0] word_q;      // bytes 0..2 of the word in progress
  logic [1:0]  byte_idx_q;
  logic [7:0]  csum_q;

  logic        accept_s;
  logic        start_load_s;
  logic [15:0] len_s;
  logic        last_word_s;
  logic [31:0] word_addr_s;

  // Handshake, length and address helpers shared by next-state and datapath.
  always_comb begin
    accept_s     = s_valid & s_ready_q;
    start_load_s = start & ((state_q == ST_IDLE) | (state_q == ST_DONE) |
                            (state_q == ST_ERR));
    len_s        = {s_data, len_lo_q};
    // Only evaluated in WRITE, where len_q is at least 1.
    last_word_s  = (words_loaded_q == (len_q - 16'd1));
    word_addr_s  = BASE_ADDR + {14'd0, words_loaded_q, 2'b00};
  end

  // Next-state decode of the load sequencer.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (start) begin
          state_d = ST_LEN_LO;
        end else begin
          state_d = state_q;
        end
      end
      ST_LEN_LO: begin
        if (accept_s) begin
          state_d = ST_LEN_HI;
        end else begin
          state_d = state_q;
        end
      end
      ST_LEN_HI: begin
        // Overflow is decided here, before any memory write can happen.
        if (accept_s) begin
          if (len_s == 16'd0) begin
            state_d = ST_CSUM;
          end else if ({1'b0, len_s} > DEPTH_LIMIT) begin
            state_d = ST_ERR;
          end else begin
            state_d = ST_DATA;
          end
        end else begin
          state_d = state_q;
        end
      end
      ST_DATA: begin
        if (accept_s && (byte_idx_q == 2'd3)) begin
          state_d = ST_WRITE;
        end else begin
          state_d = state_q;
        end
      end
      ST_WRITE: begin
        if (last_word_s) begin
          state_d = ST_CSUM;
        end else begin
          state_d = ST_DATA;
        end
      end
      ST_CSUM: begin
        if (accept_s) begin
          if (s_data == csum_q) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_ERR;
          end
        end else begin
          state_d = state_q;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Sequencer state, registered outputs and word/checksum datapath.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= ST_IDLE;
      s_ready_q      <= 1'b0;
      imem_we_q      <= 1'b0;
      imem_addr_q    <= 32'h0000_0000;
      imem_wdata_q   <= 32'h0000_0000;
      core_rst_q     <= 1'b1;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      err_q          <= 1'b0;
      words_loaded_q <= 16'd0;
      len_lo_q       <= 8'h00;
      len_q          <= 16'd0;
      word_q         <= 24'h00_0000;
      byte_idx_q     <= 2'd0;
      csum_q         <= 8'h00;
    end else begin
      state_q    <= state_d;
      // Outputs are decoded from the next state so they line up with it.
      s_ready_q  <= ready_in(state_d);
      busy_q     <= busy_in(state_d);
      imem_we_q  <= (state_d == ST_WRITE);
      done_q     <= (state_d == ST_DONE);
      err_q      <= (state_d == ST_ERR);
      // A reload re-asserts core reset on the same edge that enters LEN_LO.
      core_rst_q <= (state_d != ST_DONE);

      if (start_load_s) begin
        words_loaded_q <= 16'd0;
        csum_q         <= 8'h00;
        byte_idx_q     <= 2'd0;
        word_q         <= 24'h00_0000;
      end else begin
        case (state_q)
          ST_LEN_LO: begin
            if (accept_s) begin
              len_lo_q <= s_data;
            end
          end
          ST_LEN_HI: begin
            if (accept_s) begin
              len_q <= len_s;
            end
          end
          ST_DATA: begin
            if (accept_s) begin
              csum_q     <= csum_q ^ s_data;
              byte_idx_q <= byte_idx_q + 2'd1;
              case (byte_idx_q)
                2'd0:    word_q[7:0]   <= s_data;
                2'd1:    word_q[15:8]  <= s_data;
                2'd2:    word_q[23:16] <= s_data;
                default: begin
                  // Last byte: launch the completed word for the WRITE cycle.
                  imem_wdata_q <= {s_data, word_q};
                  imem_addr_q  <= word_addr_s;
                end
              endcase
            end
          end
          ST_WRITE: begin
            words_loaded_q <= words_loaded_q + 16'd1;
          end
          default: begin
          end
        endcase
      end
    end
  end

  assign s_ready      = s_ready_q;
  assign imem_we      = imem_we_q;
  assign imem_addr    = imem_addr_q;
  assign imem_wdata   = imem_wdata_q;
  assign core_rst     = core_rst_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign err          = err_q;
  assign words_loaded = words_loaded_q;

endmodule

// File: tb/tb_imem_stream_loader.sv
// -----------------------------------------------------------------------------
// tb_imem_stream_loader
//
// Drives byte-stream programs into imem_stream_loader (DEPTH_WORDS = 4) and
// compares every memory write and the final status against a reference model
// computed directly from the byte list: N from the first two bytes, words
// from groups of four bytes, checksum as the XOR of all data bytes.
// -----------------------------------------------------------------------------
module tb_imem_stream_loader;

  localparam int unsigned DEPTH = 4;

  logic        clk     = 1'b0;
  logic        rst     = 1'b0;
  logic        start   = 1'b0;
  logic        s_valid = 1'b0;
  logic [7:0]  s_data  = 8'h00;
  logic        s_ready;
  logic        imem_we;
  logic [31:0] imem_addr;
  logic [31:0] imem_wdata;
  logic        core_rst;
  logic        busy;
  logic        done;
  logic        err;
  logic [15:0] words_loaded;

  int          n_total = 0;
  int          n_bad   = 0;
  logic [31:0] wr_addr[$];
  logic [31:0] wr_data[$];
  int          lat_bad = 0;
  logic        prev_hs = 1'b0;
  bit          abort   = 1'b0;
  logic [7:0]  stream_q[$];

  always #5 clk = ~clk;

  imem_stream_loader #(
    .DEPTH_WORDS(DEPTH),
    .BASE_ADDR  (32'h0000_0000)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .s_data      (s_data),
    .imem_we     (imem_we),
    .imem_addr   (imem_addr),
    .imem_wdata  (imem_wdata),
    .core_rst    (core_rst),
    .busy        (busy),
    .done        (done),
    .err         (err),
    .words_loaded(words_loaded)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h", tag, got, exp);
    end
  endtask

  // Records writes; a write must follow a byte transfer on the previous edge.
  always @(negedge clk) begin
    if (!rst) begin
      prev_hs <= 1'b0;
    end else begin
      if (imem_we) begin
        wr_addr.push_back(imem_addr);
        wr_data.push_back(imem_wdata);
        if (!prev_hs) lat_bad <= lat_bad + 1;
      end
      prev_hs <= s_valid & s_ready;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Offers one byte after a random idle gap and waits (bounded) for it to transfer.
  task automatic send_byte(input logic [7:0] b, input int max_gap);
    int w;
    int gap;
    if (abort) return;
    s_valid = 1'b0;
    gap = int'($urandom_range(max_gap, 0));
    repeat (gap) begin @(posedge clk); #1; end
    s_valid = 1'b1;
    s_data  = b;
    w = 0;
    forever begin
      @(negedge clk);
      if (s_ready === 1'b1) break;
      w++;
      if (w > 100) begin
        check("s_ready_wait", 32'(s_ready), 32'd1);
        abort   = 1'b1;
        s_valid = 1'b0;
        return;
      end
    end
    @(posedge clk); #1;
    s_valid = 1'b0;
  endtask

  task automatic build_prog(input int n, input bit good);
    logic [7:0] cs;
    logic [7:0] b;
    stream_q.delete();
    stream_q.push_back(8'(n));
    stream_q.push_back(8'(n >> 8));
    if (n <= int'(DEPTH)) begin
      cs = 8'h00;
      for (int i = 0; i < 4 * n; i++) begin
        b = 8'($urandom);
        stream_q.push_back(b);
        cs ^= b;
      end
      stream_q.push_back(good ? cs : (cs ^ 8'($urandom_range(255, 1))));
    end
  endtask

  // Sends stream_q and compares writes and final status with the model.
  task automatic run_load(input string name, input int max_gap, input bit noise, input bit do_start);
    int         n;
    int         nw;
    int         wb;
    int         lb;
    bit         ovf;
    bit         exp_done;
    logic [7:0] cs;
    logic [31:0] w;
    n   = int'({stream_q[1], stream_q[0]});
    ovf = (n > int'(DEPTH));
    nw  = ovf ? 0 : n;
    cs  = 8'h00;
    exp_done = 1'b0;
    if (!ovf) begin
      for (int i = 2; i < 2 + 4 * n; i++) cs ^= stream_q[i];
      exp_done = (stream_q[2 + 4 * n] == cs);
    end
    wb = wr_addr.size();
    lb = lat_bad;
    if (do_start) pulse_start();
    for (int k = 0; k < stream_q.size(); k++) begin
      // start is ignored while the data phase is in progress
      if (noise && k >= 3 && k < stream_q.size() - 1 && !abort) pulse_start();
      send_byte(stream_q[k], max_gap);
    end
    repeat (3) @(posedge clk);
    #1;
    check({name, ":writes"}, 32'(wr_addr.size() - wb), 32'(nw));
    for (int i = 0; i < nw && (wb + i) < wr_addr.size(); i++) begin
      w = {stream_q[5 + 4 * i], stream_q[4 + 4 * i], stream_q[3 + 4 * i], stream_q[2 + 4 * i]};
      check({name, ":addr"}, wr_addr[wb + i], 32'(4 * i));
      check({name, ":data"}, wr_data[wb + i], w);
    end
    check({name, ":done"},     32'(done),         32'(exp_done));
    check({name, ":err"},      32'(err),          32'(!exp_done));
    check({name, ":core_rst"}, 32'(core_rst),     32'(!exp_done));
    check({name, ":busy"},     32'(busy),         32'd0);
    check({name, ":s_ready"},  32'(s_ready),      32'd0);
    check({name, ":we_idle"},  32'(imem_we),      32'd0);
    check({name, ":words"},    32'(words_loaded), 32'(nw));
    check({name, ":latency"},  32'(lat_bad - lb), 32'd0);
  endtask

  task automatic load_basic(input logic [7:0] csum_byte);
    stream_q = '{8'h02, 8'h00, 8'h13, 8'h05, 8'h10, 8'h00,
                 8'h93, 8'h05, 8'h20, 8'h00, csum_byte};
  endtask

  initial begin
    int wb;
    // Reset state while rst is held low
    #12;
    check("rst:core_rst", 32'(core_rst),     32'd1);
    check("rst:done",     32'(done),         32'd0);
    check("rst:err",      32'(err),          32'd0);
    check("rst:busy",     32'(busy),         32'd0);
    check("rst:we",       32'(imem_we),      32'd0);
    check("rst:s_ready",  32'(s_ready),      32'd0);
    check("rst:words",    32'(words_loaded), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    check("idle:s_ready", 32'(s_ready), 32'd0);

    // Two-word program; XOR of the eight data bytes is 0xB0
    load_basic(8'hB0);
    run_load("basic", 0, 1'b0, 1'b1);
    load_basic(8'h81);
    run_load("badsum", 0, 1'b0, 1'b1);

    // Length beyond capacity, then exactly at capacity
    stream_q = '{8'h05, 8'h00};
    run_load("ovf5", 0, 1'b0, 1'b1);
    stream_q = '{8'h00, 8'h01};
    run_load("ovf256", 1, 1'b0, 1'b1);
    build_prog(4, 1'b1);
    run_load("full", 1, 1'b0, 1'b1);

    // Stalled stream and empty loads
    load_basic(8'hB0);
    run_load("stall", 3, 1'b0, 1'b1);
    stream_q = '{8'h00, 8'h00, 8'h00};
    run_load("empty", 2, 1'b0, 1'b1);
    stream_q = '{8'h00, 8'h00, 8'h01};
    run_load("empty_bad", 0, 1'b0, 1'b1);

    // Reload straight out of DONE
    load_basic(8'hB0);
    run_load("pre_reload", 0, 1'b0, 1'b1);
    pulse_start();
    check("reload:core_rst", 32'(core_rst),     32'd1);
    check("reload:done",     32'(done),         32'd0);
    check("reload:busy",     32'(busy),         32'd1);
    check("reload:words",    32'(words_loaded), 32'd0);
    build_prog(3, 1'b1);
    run_load("reload", 2, 1'b1, 1'b0);

    // Reset in the middle of the second word
    load_basic(8'hB0);
    wb = wr_addr.size();
    pulse_start();
    for (int k = 0; k < 7; k++) send_byte(stream_q[k], 1);
    #2;
    rst = 1'b0;
    #1;
    check("midrst:core_rst", 32'(core_rst),     32'd1);
    check("midrst:done",     32'(done),         32'd0);
    check("midrst:err",      32'(err),          32'd0);
    check("midrst:busy",     32'(busy),         32'd0);
    check("midrst:we",       32'(imem_we),      32'd0);
    check("midrst:s_ready",  32'(s_ready),      32'd0);
    check("midrst:words",    32'(words_loaded), 32'd0);
    check("midrst:writes",   32'(wr_addr.size() - wb), 32'd1);
    if (wr_data.size() > wb) check("midrst:data", wr_data[wb], 32'h0010_0513);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    check("midrst:idle_ready", 32'(s_ready), 32'd0);

    // Randomized programs, including overflow and bad checksums
    for (int r = 0; r < 16; r++) begin
      build_prog(int'($urandom_range(5, 0)), ($urandom_range(3, 0) != 0));
      run_load("rnd", int'($urandom_range(2, 0)), 1'($urandom_range(1, 0)), 1'b1);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
